demux_router: RTL and testbench
===============================

// Module: demux_router
// PURPOSE
//  1-to-4 registered demultiplexer: one input stream is steered by select lines s1,s0 to one of four
//  output channels, each with a one-entry holding slot and valid/ready handshake. Counterpart of the
//  4:1 mux: fans a shared source out to four independent consumers without losing words under backpressure.
// PARAMETERS
//  WIDTH    8   data width of input word and each output channel
//  CNT_W    8   width of accepted-word counter (wraps)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous reset, active-high
//  s1,s0      in   1 each   channel select {s1,s0}: 00->y0, 01->y1, 10->y2, 11->y3
//  d          in   WIDTH    input word
//  d_valid    in   1        input word present
//  d_ready    out  1        router accepts input this cycle
//  y0..y3     out  WIDTH    channel data (registered)
//  y0_valid..y3_valid out 1 channel slot holds a word
//  y0_ready..y3_ready in  1 consumer takes word this cycle
//  count      out  CNT_W    total words accepted since reset
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): all yN_valid=0, yN=0, count=0; d_ready low during reset cycle; words in flight discarded.
//  - Each channel slot: states EMPTY/FULL. EMPTY->FULL on load; FULL->EMPTY on yN_ready with no load;
//    FULL stays FULL on load+yN_ready (new word replaces drained one); FULL with no ready holds data stable.
//  - d_ready = !rst & (!yS_valid | yS_ready), S={s1,s0}; combinational from select and selected slot only.
//  - Accept = d_valid & d_ready; on accept, d loads slot S next edge: latency 1 cycle, yS_valid=1 next cycle.
//  - Select sampled only at accept; s1,s0 may change freely while d_valid=0 or d_ready=0.
//  - Unselected channels drain independently every cycle; a full non-selected channel never blocks input.
//  - Source must hold d, s1, s0 stable while d_valid=1 and d_ready=0.
//  - yN and yN_valid change only on clk edge; yN value undefined-free: holds last word after drain.
//  - count increments by 1 per accept, wraps 2^CNT_W-1 -> 0; no increment during reset.
//  - Throughput: 1 word/cycle when selected consumer holds ready high (back-to-back to same or different channels).
// STRUCTURE
//  - Shared package demux_pkg: channel index constants CH0..CH3, slot state encoding EMPTY=0/FULL=1.
//  - Sub-module demux_slot (WIDTH): one-entry register with load, ready, valid, data; instantiated 4x.
//  - Top: select decode to one-hot load enables, d_ready mux, counter.
// TESTING
//  1 Reset: assert rst 2 cycles mid-traffic with y1 full -> all valid=0, y*=0, count=0 on next edge.
//  2 Route: sel=00..11, d=A0,A1,A2,A3, all ready=1 -> each word on y0..y3 one cycle later, count=4.
//  3 Backpressure: y2_ready=0, send 0x55 then 0x66 to sel=10 -> 0x55 held, d_ready=0 on 2nd until y2_ready=1.
//  4 Non-blocking: y2 full stalled, send 0x11 to sel=01 -> accepted, y1=0x11, y2 still 0x55.
//  5 Replace: y3 full, y3_ready=1 and new 0x77 to sel=11 same cycle -> y3=0x77, y3_valid stays 1.
//  6 Wrap: CNT_W=8, 256 accepts -> count=0; select change with d_valid=0 -> no load, count unchanged.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 registered demultiplexer.
package demux_pkg;

    localparam int unsigned NUM_CH = 4;

    // Channel indices as decoded from {s1, s0}
    localparam logic [1:0] CH0 = 2'd0;
    localparam logic [1:0] CH1 = 2'd1;
    localparam logic [1:0] CH2 = 2'd2;
    localparam logic [1:0] CH3 = 2'd3;

    // One-entry slot occupancy; encoding is fixed (empty = 0, full = 1)
    typedef enum logic {
        SlotEmpty = 1'b0,
        SlotFull  = 1'b1
    } slot_state_e;

    // Channel index to one-hot load vector
    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [1:0] sel);
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot with valid/ready handshake on the consumer side.
// The data register keeps the last word after a drain so the output never
// goes undefined.
module demux_slot
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             can_load_o
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Next-state: a load always wins and replaces a word being drained
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load_i) begin
            state_d = SlotFull;
            data_d  = data_i;
        end else if ((state_q == SlotFull) && ready_i) begin
            state_d = SlotEmpty;
        end
    end

    // State and data registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SlotEmpty;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Outputs: slot can take a word if empty or if its word leaves this cycle
    always_comb begin
        valid_o    = (state_q == SlotFull);
        data_o     = data_q;
        can_load_o = (state_q == SlotEmpty) || ready_i;
    end

endmodule

// File: rtl/demux_router.sv
// 1-to-4 registered demultiplexer: steers one input stream to one of four
// buffered output channels selected by {s1, s0}, counting accepted words.
module demux_router
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s1,
    input  logic             s0,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic             d_ready,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             y0_valid,
    output logic             y1_valid,
    output logic             y2_valid,
    output logic             y3_valid,
    input  logic             y0_ready,
    input  logic             y1_ready,
    input  logic             y2_ready,
    input  logic             y3_ready,
    output logic [CNT_W-1:0] count
);

    logic [1:0]        sel;
    logic              accept;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] slot_ready;
    logic [NUM_CH-1:0] slot_valid;
    logic [NUM_CH-1:0] slot_can_load;
    logic [WIDTH-1:0]  slot_data [NUM_CH];
    logic [CNT_W-1:0]  count_q, count_d;

    assign sel        = {s1, s0};
    assign slot_ready = {y3_ready, y2_ready, y1_ready, y0_ready};

    // Handshake and load decode; only the selected slot gates d_ready
    always_comb begin
        d_ready = !rst && slot_can_load[sel];
        accept  = d_valid && d_ready;
        load    = accept ? sel_onehot(sel) : '0;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk_i      (clk),
            .rst_i      (rst),
            .load_i     (load[i]),
            .data_i     (d),
            .ready_i    (slot_ready[i]),
            .valid_o    (slot_valid[i]),
            .data_o     (slot_data[i]),
            .can_load_o (slot_can_load[i])
        );
    end

    // Accepted-word counter next state; wraps naturally at 2^CNT_W
    always_comb begin
        count_d = count_q;
        if (accept) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign y0       = slot_data[CH0];
    assign y1       = slot_data[CH1];
    assign y2       = slot_data[CH2];
    assign y3       = slot_data[CH3];
    assign y0_valid = slot_valid[CH0];
    assign y1_valid = slot_valid[CH1];
    assign y2_valid = slot_valid[CH2];
    assign y3_valid = slot_valid[CH3];

endmodule

// File: tb/tb_demux_router.sv
// Self-checking bench for demux_router: behavioural channel model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_demux_router;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             s1, s0;
    logic [1:0]       sel_in;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic             d_ready;
    logic [WIDTH-1:0] y0, y1, y2, y3;
    logic             y0_valid, y1_valid, y2_valid, y3_valid;
    logic             y0_ready, y1_ready, y2_ready, y3_ready;
    logic [3:0]       yr;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] ya [4];
    logic [3:0]       yv;

    assign {s1, s0} = sel_in;
    assign {y3_ready, y2_ready, y1_ready, y0_ready} = yr;
    assign ya[0] = y0;
    assign ya[1] = y1;
    assign ya[2] = y2;
    assign ya[3] = y3;
    assign yv    = {y3_valid, y2_valid, y1_valid, y0_valid};

    demux_router #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s1       (s1),
        .s0       (s0),
        .d        (d),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .y0       (y0),
        .y1       (y1),
        .y2       (y2),
        .y3       (y3),
        .y0_valid (y0_valid),
        .y1_valid (y1_valid),
        .y2_valid (y2_valid),
        .y3_valid (y3_valid),
        .y0_ready (y0_ready),
        .y1_ready (y1_ready),
        .y2_ready (y2_ready),
        .y3_ready (y3_ready),
        .count    (count)
    );

    always #5 clk = ~clk;

    int unsigned passed = 0;
    int unsigned total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Reference model: per-channel occupancy and last word, plus word count
    logic [3:0]       mv;
    logic [WIDTH-1:0] md [4];
    int unsigned      mcount;
    logic             started = 1'b0;
    logic             m_ready;
    logic             m_acc;

    assign m_ready = !rst && (!mv[sel_in] || yr[sel_in]);
    assign m_acc   = d_valid && m_ready;

    // Model update on each rising edge
    always @(posedge clk) begin
        if (rst) begin
            started <= 1'b1;
            mv      <= '0;
            mcount  <= 0;
            for (int i = 0; i < 4; i++) md[i] <= '0;
        end else begin
            mcount <= (mcount + (m_acc ? 1 : 0)) % 256;
            for (int i = 0; i < 4; i++) begin
                if (m_acc && (sel_in == i[1:0])) begin
                    mv[i] <= 1'b1;
                    md[i] <= d;
                end else if (mv[i] && yr[i]) begin
                    mv[i] <= 1'b0;
                end
            end
        end
    end

    // Compare DUT against model mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("model y%0d_valid", i), 32'(yv[i]), 32'(mv[i]));
                check($sformatf("model y%0d", i), 32'(ya[i]), 32'(md[i]));
            end
            check("model count", 32'(count), mcount);
            check("model d_ready", 32'(d_ready), 32'(m_ready));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic stalled;

    initial begin
        rst     = 1'b1;
        d_valid = 1'b0;
        d       = '0;
        sel_in  = 2'd0;
        yr      = 4'hF;
        tick();
        tick();
        rst = 1'b0;

        // Fill y1 while its consumer is stalled, then reset mid-traffic
        yr      = 4'b1101;
        sel_in  = 2'd1;
        d       = 8'h3C;
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        tick();
        check("pre-reset y1_valid", 32'(y1_valid), 32'd1);
        check("pre-reset y1", 32'(y1), 32'h3C);
        rst     = 1'b1;
        d_valid = 1'b1;
        sel_in  = 2'd0;
        d       = 8'h99;
        #1 check("d_ready in reset", 32'(d_ready), 32'd0);
        tick();
        tick();
        rst     = 1'b0;
        d_valid = 1'b0;
        check("reset y1_valid", 32'(y1_valid), 32'd0);
        check("reset y1", 32'(y1), 32'd0);
        check("reset y0_valid", 32'(y0_valid), 32'd0);
        check("reset y0", 32'(y0), 32'd0);
        check("reset count", 32'(count), 32'd0);
        yr = 4'hF;

        // Route A0..A3 to y0..y3 back-to-back
        for (int k = 0; k < 4; k++) begin
            sel_in  = k[1:0];
            d       = 8'hA0 + 8'(k);
            d_valid = 1'b1;
            tick();
            check($sformatf("route y%0d_valid", k), 32'(yv[k]), 32'd1);
            check($sformatf("route y%0d", k), 32'(ya[k]), 32'hA0 + k);
        end
        d_valid = 1'b0;
        check("route count", 32'(count), 32'd4);

        // Backpressure on y2, with a non-blocked word to y1 in between
        yr      = 4'b1011;
        sel_in  = 2'd2;
        d       = 8'h55;
        d_valid = 1'b1;
        #1 check("bp first d_ready", 32'(d_ready), 32'd1);
        tick();
        check("bp y2_valid", 32'(y2_valid), 32'd1);
        check("bp y2", 32'(y2), 32'h55);
        sel_in = 2'd1;
        d      = 8'h11;
        #1 check("nonblock d_ready", 32'(d_ready), 32'd1);
        tick();
        check("nonblock y1", 32'(y1), 32'h11);
        check("nonblock y1_valid", 32'(y1_valid), 32'd1);
        check("nonblock y2 held", 32'(y2), 32'h55);
        check("nonblock y2_valid", 32'(y2_valid), 32'd1);
        sel_in = 2'd2;
        d      = 8'h66;
        #1 check("bp second d_ready", 32'(d_ready), 32'd0);
        tick();
        check("bp stall y2", 32'(y2), 32'h55);
        check("bp stall d_ready", 32'(d_ready), 32'd0);
        yr = 4'hF;
        #1 check("bp release d_ready", 32'(d_ready), 32'd1);
        tick();
        check("bp y2 after", 32'(y2), 32'h66);
        check("bp y2_valid after", 32'(y2_valid), 32'd1);
        d_valid = 1'b0;
        check("bp count", 32'(count), 32'd7);

        // Replace: load and drain y3 in the same cycle
        yr      = 4'b0111;
        sel_in  = 2'd3;
        d       = 8'h70;
        d_valid = 1'b1;
        tick();
        check("replace y3 first", 32'(y3), 32'h70);
        yr = 4'hF;
        d  = 8'h77;
        #1 check("replace d_ready", 32'(d_ready), 32'd1);
        tick();
        check("replace y3", 32'(y3), 32'h77);
        check("replace y3_valid", 32'(y3_valid), 32'd1);
        d_valid = 1'b0;
        check("replace count", 32'(count), 32'd9);

        // Counter wrap after 256 accepts, then select changes with no valid
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        d_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            sel_in = i[1:0];
            d      = i[7:0];
            tick();
        end
        d_valid = 1'b0;
        check("wrap count", 32'(count), 32'd0);
        check("wrap y3", 32'(y3), 32'hFF);
        for (int j = 0; j < 4; j++) begin
            sel_in = j[1:0];
            tick();
        end
        check("idle count", 32'(count), 32'd0);
        check("idle y0_valid", 32'(y0_valid), 32'd0);
        check("idle y3_valid", 32'(y3_valid), 32'd0);
        check("idle y3 kept", 32'(y3), 32'hFF);

        // Random traffic obeying the source hold rule
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            stalled = d_valid && !d_ready;
            tick();
            if (!stalled) begin
                d_valid = ($urandom_range(0, 3) != 0);
                sel_in  = 2'($urandom_range(0, 3));
                d       = 8'($urandom);
            end
            yr  = 4'($urandom);
            rst = ($urandom_range(0, 199) == 0);
        end
        rst     = 1'b0;
        d_valid = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
